// File: rtl/memorybank_param.sv
// Parametrised node-record bank: write port, registered read with ack, per-entry valid
// bits, occupancy flags, lowest-free index and a sequential clear sweep. Macro READ_BYPASS_EN.
module memorybank_param #(
    parameter int WORD_WIDTH = 16,
    parameter int MEM_DEPTH  = 64,
    parameter int IDX_WIDTH  = $clog2(MEM_DEPTH),
    parameter int CNT_WIDTH  = $clog2(MEM_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [IDX_WIDTH-1:0]  wr_index,
    input  logic [WORD_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic [IDX_WIDTH-1:0]  rd_index,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  rd_ack,
    output logic                  rd_hit,
    input  logic                  clr_req,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty,
    output logic [IDX_WIDTH-1:0]  free_index
);

    localparam logic [IDX_WIDTH:0]   DEPTH_W  = (IDX_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(MEM_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(MEM_DEPTH);

    typedef enum logic [0:0] {IDLE = 1'b0, SWEEP = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [IDX_WIDTH-1:0]    ptr_q, ptr_d;
    logic [MEM_DEPTH-1:0]    valid_q, valid_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d;
    logic [WORD_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    rd_ack_q, rd_ack_d;
    logic                    rd_hit_q, rd_hit_d;
    logic [WORD_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    busy_s;
    logic                    wr_in_range_s, rd_in_range_s;
    logic                    clr_start_s, sweep_s, sweep_last_s, wr_fire_s;
    logic [IDX_WIDTH-1:0]    free_s;

    assign wr_in_range_s = ({1'b0, wr_index} < DEPTH_W);
    assign rd_in_range_s = ({1'b0, rd_index} < DEPTH_W);
    assign clr_start_s   = (state_q == IDLE) && clr_req;
    assign sweep_s       = (state_q == SWEEP);
    assign sweep_last_s  = sweep_s && (ptr_q == LAST_IDX);
    // A clear request in the same idle cycle takes priority over the write.
    assign wr_fire_s     = (state_q == IDLE) && !clr_req && wr_en && wr_in_range_s;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr_req)      state_d = SWEEP; else state_d = IDLE;
            SWEEP:   if (sweep_last_s) state_d = IDLE;  else state_d = SWEEP;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_s = (state_q == SWEEP);
    end

    // Valid bits, occupancy count and sweep pointer
    always_comb begin
        valid_d = valid_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        if (clr_start_s) begin
            ptr_d = {IDX_WIDTH{1'b0}};
        end else if (sweep_s) begin
            valid_d[ptr_q] = 1'b0;
            if (valid_q[ptr_q]) count_d = count_q - CNT_WIDTH'(1);
            else                count_d = count_q;
            if (sweep_last_s)   ptr_d = {IDX_WIDTH{1'b0}};
            else                ptr_d = ptr_q + IDX_WIDTH'(1);
        end else if (wr_fire_s) begin
            valid_d[wr_index] = 1'b1;
            if (!valid_q[wr_index]) count_d = count_q + CNT_WIDTH'(1);
            else                    count_d = count_q;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Read response; data_out and rd_hit hold between reads
    always_comb begin
        rd_ack_d   = rd_en;
        data_out_d = data_out_q;
        rd_hit_d   = rd_hit_q;
        if (rd_en) begin
            if (busy_s) begin
                data_out_d = {WORD_WIDTH{1'b0}};
                rd_hit_d   = 1'b0;
`ifdef READ_BYPASS_EN
            end else if (wr_fire_s && (wr_index == rd_index)) begin
                data_out_d = data_in;
                rd_hit_d   = 1'b1;
`endif
            end else if (rd_in_range_s && valid_q[rd_index]) begin
                data_out_d = mem[rd_index];
                rd_hit_d   = 1'b1;
            end else begin
                data_out_d = {WORD_WIDTH{1'b0}};
                rd_hit_d   = 1'b0;
            end
        end else begin
            rd_ack_d = 1'b0;
        end
    end

    // Control and read-port registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= {IDX_WIDTH{1'b0}};
            valid_q    <= {MEM_DEPTH{1'b0}};
            count_q    <= {CNT_WIDTH{1'b0}};
            data_out_q <= {WORD_WIDTH{1'b0}};
            rd_ack_q   <= 1'b0;
            rd_hit_q   <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            rd_ack_q   <= rd_ack_d;
            rd_hit_q   <= rd_hit_d;
        end
    end

    // Data array has no reset; invalid entries are masked on read
    always_ff @(posedge clk) begin
        if (sweep_s) begin
            mem[ptr_q] <= {WORD_WIDTH{1'b0}};
        end else if (wr_fire_s) begin
            mem[wr_index] <= data_in;
        end
    end

    // Lowest free slot; stays 0 when every entry is valid
    always_comb begin
        free_s = {IDX_WIDTH{1'b0}};
        for (int i = MEM_DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[IDX_WIDTH'(i)]) free_s = IDX_WIDTH'(i);
            else                         free_s = free_s;
        end
    end

    assign data_out   = data_out_q;
    assign rd_ack     = rd_ack_q;
    assign rd_hit     = rd_hit_q;
    assign busy       = busy_s;
    assign count      = count_q;
    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == {CNT_WIDTH{1'b0}});
    assign free_index = free_s;

endmodule
